inst_mem_loader: RTL and testbench
==================================

// Module: inst_mem_loader
// PURPOSE
//  Write-side partner of the byte-addressed instruction memory: accepts a byte stream (valid/ready) and
//  writes it into instruction memory starting at BASE_ADDR, little-endian (byte k -> address BASE_ADDR+k).
//  Holds the core in reset (cpu_hold) while a load is in progress; pulses load_done at completion.
// PARAMETERS
//  MEM_BYTES  16  instruction memory size in bytes; load lengths above this are rejected
//  ADDR_W     64  width of mem_addr; matches the core's instruction address width
//  BASE_ADDR  0   byte address of the first loaded byte
// PORTS
//  clk        in   1       single clock; all state changes on rising edge
//  reset      in   1       synchronous, active-high
//  load_start in   1       one-cycle request to begin a load; sampled in IDLE only
//  load_len   in   16      byte count, sampled with load_start
//  in_valid   in   1       stream byte valid
//  in_data    in   8       stream byte
//  in_ready   out  1       loader accepts a byte this cycle
//  mem_we     out  1       byte write strobe to instruction memory
//  mem_addr   out  ADDR_W  byte write address
//  mem_wdata  out  8       byte write data
//  cpu_hold   out  1       1 while loading; core kept in reset
//  busy       out  1       1 in any state other than IDLE
//  load_done  out  1       one-cycle pulse when a load ends (success or error)
//  load_err   out  1       sticky error flag, cleared by next accepted load_start
// BEHAVIOUR
//  Reset (synchronous, active-high): all outputs 0, state IDLE, counters 0; applies mid-load, partial data left in memory.
//  States: IDLE -> LOAD -> [CHECK] -> DONE -> IDLE.
//  IDLE: in_ready=0. load_start=1: if load_len>MEM_BYTES -> load_err=1, go DONE, no writes;
//   if load_len==0 -> go DONE, no writes; else latch len, cnt=0, clear load_err, go LOAD.
//  LOAD: in_ready=1, cpu_hold=1. Handshake = in_valid&in_ready. On handshake at edge N:
//   registered at N+1: mem_we=1, mem_addr=BASE_ADDR+cnt, mem_wdata=in_data; cnt++. One byte per cycle max.
//   mem_we=0 in every cycle without a preceding handshake. After byte len-1: go CHECK if enabled, else DONE.
//  DONE: one cycle; load_done=1, cpu_hold=0, in_ready=0; next state IDLE. busy falls with IDLE.
//  load_start outside IDLE ignored. cnt is ADDR_W-agnostic 16-bit; no wrap possible given length check.
//  Bytes presented while in_ready=0 are not consumed; stream source must hold them.
//  Latency: byte handshake -> memory write 1 cycle; last handshake -> load_done 2 cycles (no checksum).
// CONFIGURATION
//  Macro INST_MEM_LOADER_CHECKSUM_EN.
//  Defined: 8-bit running sum (mod 256) of all data bytes; CHECK state accepts one extra byte (in_ready=1,
//   cpu_hold=1, no memory write); if byte != two's complement of sum -> load_err=1; then DONE.
//  Undefined: no CHECK state, no sum register; LOAD goes directly to DONE after last byte.
// STRUCTURE
//  Shared package riscv_mem_pkg: state encoding (IDLE/LOAD/CHECK/DONE), MEM_BYTES default, BASE_ADDR default.
//  Optional sub-module loader_checksum (clear, accumulate, compare); instantiated only under the macro.
//  Remainder (FSM, counter, write register) stays in this module.
// TESTING
//  1 Load 4 bytes 93 80 01 00, in_valid held 1 -> writes addr 0..3 on consecutive cycles, load_done 2 cycles after last, err=0.
//  2 load_len=17 with MEM_BYTES=16 -> no mem_we, load_done next+1 cycle, load_err=1, cpu_hold never 1.
//  3 load_len=0 -> no writes, load_done pulse, load_err=0.
//  4 Bursty in_valid (1,0,0,1,...) over 8 bytes -> exactly 8 writes, addresses 0..7 in order, no gaps skipped.
//  5 reset asserted after 2 of 4 bytes -> next cycle all outputs 0, IDLE; new load_start accepted normally.
//  6 Checksum build: bytes 01 02 03 + check FA -> err=0; check FB -> err=1; 3 writes either way.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the instruction-memory side of the core.
// Holds the loader FSM state encoding and the default memory geometry.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StCheck = 2'd2,
    StDone  = 2'd3
  } loader_state_e;

  localparam int unsigned MemBytesDefault = 16;
  localparam logic [63:0] BaseAddrDefault = 64'h0;

endpackage

// File: rtl/loader_checksum.sv
// Running 8-bit checksum for the instruction memory loader.
// Accumulates data bytes mod 256 and reports whether a trailing check byte
// is the two's complement of the sum (i.e. sum + check == 0).
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   clear_i        : zero the running sum (start of a new load)
//   accum_i        : add data_i to the running sum
//   data_i         : data byte to accumulate
//   check_i        : candidate check byte
//   match_o        : 1 when check_i closes the sum to zero
module loader_checksum (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       accum_i,
  input  logic [7:0] data_i,
  input  logic [7:0] check_i,
  output logic       match_o
);

  logic [7:0] sum_q, sum_d;
  logic [7:0] total;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = 8'h00;
    end else if (accum_i) begin
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign total   = sum_q + check_i;
  assign match_o = (total == 8'h00);

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: takes a valid/ready byte stream and writes it
// little-endian into the byte-addressed instruction memory from BASE_ADDR.
// Holds the core in reset (cpu_hold) while loading and pulses load_done at
// the end of every load, successful or not.
// Optional feature: define INST_MEM_LOADER_CHECKSUM_EN to require a trailing
// check byte equal to the two's complement of the 8-bit data sum.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   load_start/load_len : start request and byte count (sampled in idle)
//   in_valid/in_data    : stream byte in; in_ready accepts it
//   mem_we/addr/wdata   : registered byte write to instruction memory
//   cpu_hold            : 1 while bytes are being accepted
//   busy                : 1 whenever the loader is not idle
//   load_done           : one-cycle end-of-load pulse
//   load_err            : sticky error, cleared by the next accepted start
module inst_mem_loader
  import riscv_mem_pkg::*;
#(
  parameter int unsigned       MEM_BYTES = MemBytesDefault,
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BaseAddrDefault)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [15:0]       load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  loader_state_e     state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              done_q;

  logic handshake;
  logic last_byte;
  logic sum_clear;
  logic sum_accum;
  logic sum_match;

  assign in_ready  = (state_q == StLoad) || (state_q == StCheck);
  assign handshake = in_valid && in_ready;
  assign last_byte = (cnt_q == len_q - 16'd1);

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  loader_checksum u_checksum (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (sum_clear),
    .accum_i (sum_accum),
    .data_i  (in_data),
    .check_i (in_data),
    .match_o (sum_match)
  );
`else
  logic unused_sum;
  assign sum_match  = 1'b1;
  assign unused_sum = sum_clear ^ sum_accum;
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sum_clear = 1'b0;
    sum_accum = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          err_d = 1'b0;
          if (32'(load_len) > MEM_BYTES) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (load_len == 16'd0) begin
            state_d = StDone;
          end else begin
            len_d     = load_len;
            cnt_d     = 16'd0;
            sum_clear = 1'b1;
            state_d   = StLoad;
          end
        end
      end
      StLoad: begin
        if (handshake) begin
          we_d      = 1'b1;
          addr_d    = BASE_ADDR + ADDR_W'(cnt_q);
          wdata_d   = in_data;
          cnt_d     = cnt_q + 16'd1;
          sum_accum = 1'b1;
          if (last_byte) begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
`endif
          end
        end
      end
      StCheck: begin
        // Check byte is consumed but never written to memory.
        if (handshake) begin
          if (!sum_match) begin
            err_d = 1'b1;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= 16'd0;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      // Registered so the pulse lands two cycles after the final handshake.
      done_q  <= (state_q == StDone);
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = in_ready;
  assign busy      = (state_q != StIdle);
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  localparam int unsigned MemBytes = 16;
  localparam int unsigned AddrW    = 64;
  localparam logic [63:0] Base     = 64'h0;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             load_start = 1'b0;
  logic [15:0]      load_len = 16'd0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready;
  logic             mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [7:0]       mem_wdata;
  logic             cpu_hold;
  logic             busy;
  logic             load_done;
  logic             load_err;

  inst_mem_loader #(
    .MEM_BYTES (MemBytes),
    .ADDR_W    (AddrW),
    .BASE_ADDR (Base)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        exp_wr[$];
  bit         exp_done[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         prev_err = 1'b0;
  logic [7:0] data_buf [0:31];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or signals done.
  initial begin : monitor
    bit prev_hs = 1'b0;
    int last_ev = 0;
    wr_t e;
    bit  d;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hs = 1'b0;
        continue;
      end
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", {56'h0, mem_wdata}, {56'h0, e.data});
        end
        chk("wr_latency", {63'h0, prev_hs}, 64'd1);
      end
      if (load_done) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          d = exp_done.pop_front();
          chk("done_err", {63'h0, load_err}, {63'h0, d});
        end
        chk("done_latency", 64'(cyc - last_ev), 64'd2);
        chk("done_hold", {63'h0, cpu_hold}, 64'd0);
      end
      if (load_start && !busy) last_ev = cyc;
      prev_hs = in_valid && in_ready;
      if (prev_hs) last_ev = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One load. abort_after >= 0 applies reset after that many accepted bytes.
  task automatic run_load(input int len, input int abort_after, input bit bursty,
                          input bit bad_ck);
    int         t;
    int         k;
    int         total;
    bit         exp_err;
    bit         v;
    logic [7:0] sum;
    logic [7:0] ck;

    t = 0;
    while (busy && t < 50) begin
      tick();
      t++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    chk("err_sticky", {63'h0, load_err}, {63'h0, prev_err});

    load_start = 1'b1;
    load_len   = 16'(len);
    tick();
    load_start = 1'b0;
    load_len   = $urandom_range(0, 65535);

    if (len == 0 || len > int'(MemBytes)) begin
      exp_err = (len > int'(MemBytes));
      exp_done.push_back(exp_err);
      for (int i = 0; i < 3; i++) begin
        chk("no_hold", {63'h0, cpu_hold}, 64'd0);
        chk("no_write", {63'h0, mem_we}, 64'd0);
        tick();
      end
      prev_err = exp_err;
      return;
    end

    sum = 8'h00;
    for (int i = 0; i < len; i++) sum = sum + data_buf[i];
    ck = 8'h00 - sum;
    if (bad_ck) ck = ck ^ 8'h01;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    total   = len + 1;
    exp_err = bad_ck;
`else
    total   = len;
    exp_err = 1'b0;
`endif

    k = 0;
    t = 0;
    while (k < total && t < 400) begin
      if (k == abort_after) break;
      v        = bursty ? ($urandom_range(0, 2) == 0) : 1'b1;
      in_valid = v;
      in_data  = (k < len) ? data_buf[k] : ck;
      if (v && in_ready) begin
        if (k < len) exp_wr.push_back('{addr: Base + 64'(k), data: data_buf[k]});
        k++;
      end
      tick();
      t++;
    end
    in_valid = 1'b0;
    if (k < total && k != abort_after) chk("stream_timeout", 1, 0);

    if (abort_after >= 0) begin
      tick();
      reset = 1'b1;
      tick();
      chk("rst_ready", {63'h0, in_ready}, 64'd0);
      chk("rst_we", {63'h0, mem_we}, 64'd0);
      chk("rst_addr", mem_addr, 64'd0);
      chk("rst_wdata", {56'h0, mem_wdata}, 64'd0);
      chk("rst_hold", {63'h0, cpu_hold}, 64'd0);
      chk("rst_busy", {63'h0, busy}, 64'd0);
      chk("rst_done", {63'h0, load_done}, 64'd0);
      chk("rst_err", {63'h0, load_err}, 64'd0);
      reset    = 1'b0;
      prev_err = 1'b0;
      return;
    end

    exp_done.push_back(exp_err);
    repeat (4) tick();
    prev_err = exp_err;
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_we", {63'h0, mem_we}, 64'd0);
    chk("reset_busy", {63'h0, busy}, 64'd0);
    chk("reset_hold", {63'h0, cpu_hold}, 64'd0);
    chk("reset_err", {63'h0, load_err}, 64'd0);
    chk("reset_done", {63'h0, load_done}, 64'd0);
    reset = 1'b0;
    tick();

    // Four bytes, stream always valid.
    data_buf[0] = 8'h93;
    data_buf[1] = 8'h80;
    data_buf[2] = 8'h01;
    data_buf[3] = 8'h00;
    run_load(4, -1, 1'b0, 1'b0);

    // Too long, then empty.
    run_load(17, -1, 1'b0, 1'b0);
    run_load(0, -1, 1'b0, 1'b0);

    // Bursty stream over eight bytes.
    for (int i = 0; i < 8; i++) data_buf[i] = 8'($urandom);
    run_load(8, -1, 1'b1, 1'b0);

    // Reset mid-load, then a normal load.
    for (int i = 0; i < 4; i++) data_buf[i] = 8'($urandom);
    run_load(4, 2, 1'b0, 1'b0);
    run_load(4, -1, 1'b0, 1'b0);

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    data_buf[0] = 8'h01;
    data_buf[1] = 8'h02;
    data_buf[2] = 8'h03;
    run_load(3, -1, 1'b0, 1'b0);
    run_load(3, -1, 1'b0, 1'b1);
`endif

    // Random loads across the length boundary.
    for (int n = 0; n < 25; n++) begin
      int len;
      len = $urandom_range(0, 18);
      for (int i = 0; i < 32; i++) data_buf[i] = 8'($urandom);
      run_load(len, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) tick();
    chk("writes_drained", 64'(exp_wr.size()), 64'd0);
    chk("dones_drained", 64'(exp_done.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
